// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronises and filters the analog POR_N, then
// releases NUM_CH active-low domain resets in order with programmable spacing.
// Any POR drop or software reset request re-asserts every channel at once.
module por_reset_sequencer #(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 12,
   parameter int FILT_LEN  = 4,
   parameter int INIT_DLY  = 20,
   parameter int STAGE_DLY = 20
) (
   input  logic                        CLK_I,
   input  logic                        RST_I,
   input  logic                        POR_N_I,
   input  logic                        SW_RST_I,
   input  logic [NUM_CH-1:0]           HOLD_I,
   output logic [NUM_CH-1:0]           RST_N_O,
   output logic                        READY_O,
   output logic [$clog2(NUM_CH+1)-1:0] STAGE_O
);

   localparam int IDX_W = $clog2(NUM_CH + 1);
   localparam int FC_W  = $clog2(FILT_LEN + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
   localparam logic [FC_W-1:0]  FILT_TGT  = FC_W'(FILT_LEN);
   localparam logic [CNT_W-1:0] INIT_TGT  = CNT_W'(INIT_DLY);
   localparam logic [CNT_W-1:0] STAGE_TGT = CNT_W'(STAGE_DLY);

   typedef enum logic [1:0] {
      S_ASSERT,
      S_FILTER,
      S_RELEASE,
      S_RUN
   } state_t;

   logic [1:0]        sync_q;
   state_t            state_q, state_d;
   logic [FC_W-1:0]   fcnt_q,  fcnt_d;
   logic [CNT_W-1:0]  dly_q,   dly_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [NUM_CH-1:0] rst_n_q, rst_n_d;
   logic              ready_q, ready_d;

   logic              por_s;
   logic              abort;
   logic              hold_cur;
   logic              tgt_hit;
   logic [CNT_W-1:0]  tgt;
   logic [NUM_CH-1:0] sel;

   assign por_s    = sync_q[1];
   assign abort    = ~por_s | SW_RST_I;
   // one-hot pointer to the channel currently being sequenced
   assign sel      = NUM_CH'(1) << idx_q;
   assign hold_cur = |(HOLD_I & sel);
   assign tgt      = (idx_q == '0) ? INIT_TGT : STAGE_TGT;
   // tgt is at least 1, and comparing against tgt-1 keeps a counter parked
   // at 2^CNT_W-1 from overflowing
   assign tgt_hit  = (dly_q >= tgt - CNT_W'(1));

   // two-flop synchroniser on the asynchronous POR_N
   always_ff @(posedge CLK_I) begin
      if (RST_I) sync_q <= '0;
      else       sync_q <= {sync_q[0], POR_N_I};
   end

   // state and output registers
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= S_ASSERT;
         fcnt_q  <= '0;
         dly_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         dly_q   <= dly_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         ready_q <= ready_d;
      end
   end

   // next-state: filter, timed release with hold, abort back to ASSERT
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      dly_d   = dly_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      ready_d = ready_q;
      if (state_q != S_ASSERT && abort) begin
         // abort beats a release due on the same edge
         state_d = S_ASSERT;
         fcnt_d  = '0;
         dly_d   = '0;
         idx_d   = '0;
         rst_n_d = '0;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            S_ASSERT: begin
               rst_n_d = '0;
               ready_d = 1'b0;
               idx_d   = '0;
               if (por_s && !SW_RST_I) begin
                  // this cycle is already the first good sample
                  state_d = S_FILTER;
                  fcnt_d  = FC_W'(1);
               end
            end
            S_FILTER: begin
               if (fcnt_q == FILT_TGT) begin
                  state_d = S_RELEASE;
                  dly_d   = '0;
                  idx_d   = '0;
               end else begin
                  fcnt_d = fcnt_q + FC_W'(1);
               end
            end
            S_RELEASE: begin
               if (!tgt_hit) begin
                  dly_d = dly_q + CNT_W'(1);
               end else if (hold_cur) begin
                  // park at the target until the hold drops
                  dly_d = tgt;
               end else begin
                  rst_n_d = rst_n_q | sel;
                  idx_d   = idx_q + IDX_W'(1);
                  dly_d   = '0;
                  if (idx_q == LAST_IDX) begin
                     state_d = S_RUN;
                     ready_d = 1'b1;
                  end
               end
            end
            S_RUN: begin
               ready_d = 1'b1;
            end
            default: state_d = S_ASSERT;
         endcase
      end
   end

   assign RST_N_O = rst_n_q;
   assign READY_O = ready_q;
   // channels are released strictly in order, so the index is the popcount
   assign STAGE_O = idx_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Bench for por_reset_sequencer: directed timing scenarios plus a randomized
// run checked cycle-by-cycle against a milestone-based reference model.
module tb_por_reset_sequencer;

   localparam int NCH  = 4;
   localparam int FL   = 4;
   localparam int IDLY = 20;
   localparam int SDLY = 20;

   logic       clk = 1'b0;
   logic       rst, por, sw;
   logic [3:0] hold;
   logic [3:0] rst_n;
   logic       ready;
   logic [2:0] stage;

   logic       por1, sw1, hold1;
   logic       rst_n1, ready1, stage1;

   int n_tests = 0;
   int n_fail  = 0;
   int rise_e[4];
   int rdy_e;
   int stg_e[5];

   always #5 clk = ~clk;

   por_reset_sequencer u_dut (
      .CLK_I(clk), .RST_I(rst), .POR_N_I(por), .SW_RST_I(sw), .HOLD_I(hold),
      .RST_N_O(rst_n), .READY_O(ready), .STAGE_O(stage)
   );

   por_reset_sequencer #(.NUM_CH(1), .FILT_LEN(1), .INIT_DLY(1)) u_dut1 (
      .CLK_I(clk), .RST_I(rst), .POR_N_I(por1), .SW_RST_I(sw1), .HOLD_I(hold1),
      .RST_N_O(rst_n1), .READY_O(ready1), .STAGE_O(stage1)
   );

   // Reference model: counts consecutive good edges (por_s high, no sw reset);
   // once FL+1 good edges have passed the release schedule starts, and each
   // channel is due a fixed gap after the previous milestone, deferred while
   // its hold bit is set.
   logic m_p1, m_p2;
   int   m_good, m_since, m_nrel;
   int   nx_good, nx_since, nx_nrel, gap;

   always_comb begin
      nx_good  = m_good;
      nx_since = m_since;
      nx_nrel  = m_nrel;
      gap      = (m_nrel == 0) ? IDLY : SDLY;
      if (!m_p2 || sw) begin
         nx_good  = 0;
         nx_since = 0;
         nx_nrel  = 0;
      end else if (m_good < FL + 1) begin
         nx_good  = m_good + 1;
         nx_since = 0;
      end else if (m_nrel < NCH) begin
         if (m_since + 1 >= gap && !hold[m_nrel]) begin
            nx_nrel  = m_nrel + 1;
            nx_since = 0;
         end else begin
            nx_since = m_since + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_p1 <= 1'b0; m_p2 <= 1'b0;
         m_good <= 0; m_since <= 0; m_nrel <= 0;
      end else begin
         m_p1 <= por; m_p2 <= m_p1;
         m_good <= nx_good; m_since <= nx_since; m_nrel <= nx_nrel;
      end
   end

   // records the first edge (0 = first edge of the call) each output rises
   task automatic watch(input int n, input int hrel);
      for (int i = 0; i < 4; i++) rise_e[i] = -1;
      for (int k = 0; k < 5; k++) stg_e[k] = -1;
      rdy_e = -1;
      for (int e = 0; e < n; e++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) if (rise_e[i] < 0 && rst_n[i]) rise_e[i] = e;
         if (rdy_e < 0 && ready) rdy_e = e;
         if (stg_e[stage] < 0) stg_e[stage] = e;
         if (e == hrel - 1) hold = '0;
      end
   endtask

   task automatic reset_dut(input logic p);
      rst = 1'b1; por = p; por1 = p; sw = 1'b0; sw1 = 1'b0; hold = '0; hold1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; por = 1'b1; por1 = 1'b1; sw = 1'b0; sw1 = 1'b0; hold = 4'hF; hold1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({rst_n, ready, stage} !== 8'h00) begin
         n_fail++; $display("FAIL reset_state: got %b want 0", {rst_n, ready, stage});
      end
      n_tests++;
      if ({rst_n1, ready1, stage1} !== 3'b000) begin
         n_fail++; $display("FAIL reset_state_1ch: got %b want 0", {rst_n1, ready1, stage1});
      end
      hold = '0; hold1 = 1'b0; rst = 1'b0;
      watch(30, -1);
      n_tests++;
      if (rise_e[0] !== 26) begin
         n_fail++; $display("FAIL reset_first_rise: got %0d want 26", rise_e[0]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({rst_n, ready, stage} !== 8'h00) begin
         n_fail++; $display("FAIL mid_reset_clear: got %b want 0", {rst_n, ready, stage});
      end
      rst = 1'b0;
      watch(30, -1);
      n_tests++;
      if (rise_e[0] !== 26) begin
         n_fail++; $display("FAIL mid_reset_restart: got %0d want 26", rise_e[0]);
      end
   endtask

   task automatic test_clean;
      reset_dut(1'b1);
      watch(100, -1);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rise_e[i] !== 26 + 20 * i) begin
            n_fail++; $display("FAIL clean_rise%0d: got %0d want %0d", i, rise_e[i], 26 + 20 * i);
         end
         n_tests++;
         if (stg_e[i+1] !== 26 + 20 * i) begin
            n_fail++; $display("FAIL clean_stage%0d: got %0d want %0d", i + 1, stg_e[i+1], 26 + 20 * i);
         end
      end
      n_tests++;
      if (rdy_e !== 86) begin
         n_fail++; $display("FAIL clean_ready: got %0d want 86", rdy_e);
      end
   endtask

   task automatic test_glitch;
      reset_dut(1'b1);
      repeat (4) @(posedge clk);
      #1 por = 1'b0;
      repeat (2) @(posedge clk);
      #1 por = 1'b1;
      n_tests++;
      if (rst_n !== 4'b0000) begin
         n_fail++; $display("FAIL glitch_no_release: got %b want 0000", rst_n);
      end
      watch(40, -1);
      n_tests++;
      if (rise_e[0] !== 26) begin
         n_fail++; $display("FAIL glitch_rise0: got %0d want 26", rise_e[0]);
      end
   endtask

   task automatic test_hold;
      reset_dut(1'b1);
      hold = 4'b0100;
      watch(140, 100);
      n_tests++;
      if ({rise_e[0], rise_e[1], rise_e[2], rise_e[3]} !== {32'sd26, 32'sd46, 32'sd100, 32'sd120}) begin
         n_fail++; $display("FAIL hold_rises: got %0d/%0d/%0d/%0d want 26/46/100/120",
                            rise_e[0], rise_e[1], rise_e[2], rise_e[3]);
      end
      n_tests++;
      if (rdy_e !== 120) begin
         n_fail++; $display("FAIL hold_ready: got %0d want 120", rdy_e);
      end
   endtask

   task automatic test_sw_rst;
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL sw_pre_ready: got %b want 1", ready);
      end
      sw = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({rst_n, ready, stage} !== 8'h00) begin
         n_fail++; $display("FAIL sw_assert: got %b want 0", {rst_n, ready, stage});
      end
      sw = 1'b0;
      watch(100, -1);
      n_tests++;
      if (rise_e[0] !== 24 || rise_e[3] !== 84 || rdy_e !== 84) begin
         n_fail++; $display("FAIL sw_resequence: got %0d/%0d/%0d want 24/84/84",
                            rise_e[0], rise_e[3], rdy_e);
      end
   endtask

   task automatic test_por_drop;
      reset_dut(1'b1);
      watch(50, -1);
      n_tests++;
      if (rst_n !== 4'b0011) begin
         n_fail++; $display("FAIL drop_pre: got %b want 0011", rst_n);
      end
      por = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (rst_n !== 4'b0011) begin
         n_fail++; $display("FAIL drop_edge2: got %b want 0011", rst_n);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({rst_n, ready, stage} !== 8'h00) begin
         n_fail++; $display("FAIL drop_edge3: got %b want 0", {rst_n, ready, stage});
      end
      repeat (5) @(posedge clk);
      #1 por = 1'b1;
      watch(100, -1);
      n_tests++;
      if (rise_e[0] !== 26 || rise_e[3] !== 86 || rdy_e !== 86) begin
         n_fail++; $display("FAIL drop_recover: got %0d/%0d/%0d want 26/86/86",
                            rise_e[0], rise_e[3], rdy_e);
      end
   endtask

   task automatic test_param_sweep;
      int r1, y1;
      r1 = -1; y1 = -1;
      reset_dut(1'b1);
      for (int e = 0; e < 10; e++) begin
         @(posedge clk); #1;
         if (r1 < 0 && rst_n1) r1 = e;
         if (y1 < 0 && ready1) y1 = e;
      end
      n_tests++;
      if (r1 !== 4 || y1 !== 4) begin
         n_fail++; $display("FAIL sweep_1ch: got rise %0d ready %0d want 4/4", r1, y1);
      end
      n_tests++;
      if (stage1 !== 1'b1) begin
         n_fail++; $display("FAIL sweep_stage: got %b want 1", stage1);
      end
   endtask

   task automatic test_random;
      int por_lo, sw_hi;
      logic [3:0] e_rst;
      logic       e_rdy;
      logic [2:0] e_stg;
      por_lo = 0; sw_hi = 0;
      reset_dut(1'b1);
      for (int c = 0; c < 4000; c++) begin
         if (por_lo > 0) por_lo--;
         else if ($urandom_range(0, 249) == 0) por_lo = $urandom_range(1, 8);
         if (sw_hi > 0) sw_hi--;
         else if ($urandom_range(0, 499) == 0) sw_hi = $urandom_range(1, 3);
         if ($urandom_range(0, 39) == 0) hold = 4'($urandom & $urandom);
         por = (por_lo == 0);
         sw  = (sw_hi != 0);
         rst = ($urandom_range(0, 1499) == 0);
         @(posedge clk); #1;
         e_rst = 4'((1 << m_nrel) - 1);
         e_rdy = (m_nrel == NCH);
         e_stg = 3'(m_nrel);
         n_tests++;
         if ({rst_n, ready, stage} !== {e_rst, e_rdy, e_stg}) begin
            n_fail++;
            $display("FAIL random_c%0d: got rst_n=%b rdy=%b stg=%0d want rst_n=%b rdy=%b stg=%0d",
                     c, rst_n, ready, stage, e_rst, e_rdy, e_stg);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_glitch();
      test_hold();
      test_sw_rst();
      test_por_drop();
      test_param_sweep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/por_reset_sequencer.md
# por_reset_sequencer

Parametrised digital power-on reset sequencer sitting directly behind the analog POR core cell. It synchronises and glitch-filters the raw active-low POR indication, then releases NUM_CH active-low domain resets one after another with programmable spacing. Any POR drop or software reset request re-asserts all of them at once. It replaces a single fixed-delay reset output with an ordered, holdable, multi-channel release and a ready indication for the core.

## Interface
Parameters:
- NUM_CH, default 4: number of sequenced reset channels; legal range 1..16.
- CNT_W, default 12: width of the delay counter.
- FILT_LEN, default 4: number of consecutive synchronised-high POR samples required; must be ≥1.
- INIT_DLY, default 20: cycles from end of filtering to release of channel 0; range 1..2^CNT_W-1.
- STAGE_DLY, default 20: cycles between successive channel releases; range 1..2^CNT_W-1.

Ports:
- CLK_I, input, 1: the single clock.
- RST_I, input, 1: reset; one clock, reset is synchronous and active-high.
- POR_N_I, input, 1: raw POR_N from the analog POR core; asynchronous, synchronised internally.
- SW_RST_I, input, 1: software reset request, level-sensitive, synchronous to CLK_I.
- HOLD_I, input, NUM_CH: per-channel release hold; bit i stalls the sequence at channel i.
- RST_N_O, output, NUM_CH: active-low domain resets; bit 0 is released first.
- READY_O, output, 1: high once all channels are released.
- STAGE_O, output, $clog2(NUM_CH+1): number of channels currently released.

## Operation
- Synchroniser: a 2-flop chain on POR_N_I, cleared to 0 by RST_I. The result is por_s.
- FSM states: ASSERT, FILTER, RELEASE, RUN.
- ASSERT: RST_N_O all 0, READY_O 0, STAGE_O 0.
  - Go to FILTER when por_s=1 and SW_RST_I=0. That cycle counts as filter sample 1.
- FILTER: count consecutive cycles with por_s=1.
  - Return to ASSERT on por_s=0 or SW_RST_I=1.
  - At count FILT_LEN, go to RELEASE with the delay counter at 0 and channel index 0.
- RELEASE: the delay counter increments each cycle.
  - Target is INIT_DLY for index 0 and STAGE_DLY otherwise.
  - When the target is reached and HOLD_I[idx]=0: RST_N_O[idx] goes to 1, idx increments, and the counter clears.
  - When the target is reached and HOLD_I[idx]=1: the counter saturates at the target. The channel is released on the first edge where HOLD_I[idx]=0.
  - Spacing to the next channel is measured from the actual release.
  - After the channel NUM_CH-1 release, go to RUN.
- RUN: READY_O=1 and HOLD_I is ignored.
- Abort: por_s=0 or SW_RST_I=1 in FILTER, RELEASE or RUN sends the FSM to ASSERT. All RST_N_O and READY_O go low on the next edge.
- SW_RST_I held high keeps the FSM in ASSERT. Sequencing restarts from the filter on its deassertion.
- Released channels are never re-asserted individually. HOLD_I on an already-released channel has no effect.
- STAGE_O equals the popcount of RST_N_O, always.
- The counter never wraps; saturation applies only under hold.

## Timing
- Under RST_I, all registers clear: RST_N_O=0, READY_O=0, STAGE_O=0, state=ASSERT, synchroniser=0. RST_I dominates every other input.
- Release latency, assuming POR_N_I stable high, SW_RST_I=0 and HOLD_I=0, and counting from the first edge sampling POR_N_I=1 with RST_I=0:
  - RST_N_O[0] rises 2+FILT_LEN+INIT_DLY edges later (26 at defaults).
  - RST_N_O[i] rises i*STAGE_DLY edges after RST_N_O[0].
  - READY_O and RST_N_O[NUM_CH-1] rise on the same edge (86 at defaults).
- Assertion latency:
  - POR_N_I low to all outputs low: 3 edges (2 sync + 1 FSM).
  - SW_RST_I to all outputs low: 1 edge.
- A POR glitch shorter than FILT_LEN during FILTER restarts filtering from zero.
- A simultaneous abort and channel release resolves to abort; no output rises.
- RST_I applied mid-sequence clears everything in the same edge, including the synchroniser.

## Test plan
- Clean power-up, defaults: deassert RST_I with POR_N_I=1 → RST_N_O bits rise at edges 26/46/66/86, READY_O at 86, STAGE_O steps 1,2,3,4.
- Filter glitch: POR_N_I high, then low for 2 cycles after por_s has been high 3 cycles → FSM returns to ASSERT; RST_N_O[0] rises 26 edges after POR_N_I returns high.
- Hold: HOLD_I[2]=1 until edge 100 → RST_N_O[2] rises at edge 100 (deferred from 66), RST_N_O[3] at 120, READY_O at 120.
- Software reset in RUN: 1-cycle SW_RST_I pulse → all RST_N_O=0 and READY_O=0 on the next edge; full re-sequence with RST_N_O[0] rising 4+20 edges after the pulse ends.
- POR drop mid-release, after channel 1 released: POR_N_I low → all outputs 0 three edges later; recovery timing matches clean power-up.
- Parameter sweep: NUM_CH=1 with FILT_LEN=1, INIT_DLY=1 → RST_N_O[0] and READY_O rise 4 edges after POR_N_I is sampled high.
